pc_sequencer: RTL

- Parametrised next-generation program counter for the simple processor datapath.
- Replaces the fixed 8-bit register-plus-incrementer pair with a single sequenced block.
- Selects next PC from: increment, absolute jump, sign-extended relative branch, or optional call/return stack.
- Adds stall and halt/resume control; feeds instruction-memory address and the link/return path.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_return_stack.sv | 38 +++
 rtl/pc_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// State encoding, next-PC source select and a width-generic sign extender.
package pc_seq_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SRC_INC,
        SRC_BR,
        SRC_JMP,
        SRC_CALL,
        SRC_RET,
        SRC_HOLD
    } src_e;

    // Sign-extends the low 'ow' bits of 'off' to 32 bits; callers truncate to their own width.
    function automatic logic [31:0] sext(input logic [31:0] off, input int ow);
        logic [31:0] shl;
        shl = off << (32 - ow);
        return $signed(shl) >>> (32 - ow);
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for the sequencer's call/ret path.
// Overflowing pushes and underflowing pops are dropped; the caller raises the flags.
module pc_return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]                  cnt_q;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;

    // cnt_q is the occupancy; its MSB alone marks full because DEPTH is a power of two.
    assign full_o  = cnt_q[PW];
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[cnt_q[PW-1:0] - PW'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            mem_q[cnt_q[PW-1:0]] <= din_i;
            cnt_q                <= cnt_q + (PW+1)'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, jump, relative branch, halt/resume, stall.
// Define PC_SEQUENCER_CALL_STACK_EN to add the call/return stack and its sticky flags.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               OFFSET_W    = 5,
    parameter logic [WIDTH-1:0] RESET_VEC   = '0,
    parameter int               STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                halt,
    input  logic                resume,
    input  logic                jump,
    input  logic [WIDTH-1:0]    jump_target,
    input  logic                branch,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  logic                call,
    input  logic                ret,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_plus1,
    output logic                halted,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam logic [0:0] ST_RUN    = RUN;
    localparam logic [0:0] ST_HALTED = HALTED;

    logic [WIDTH-1:0] pc_q, pc_d, br_tgt, stk_top;
    logic [0:0]       state_q, state_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push, pop, stk_full, stk_empty, ret_en;
    src_e             src;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam bit CS_EN = 1'b1;

    assign ret_en = ret;

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pc_plus1),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );
`else
    localparam bit CS_EN = 1'b0;

    logic [2:0] unused_stk;

    assign ret_en     = 1'b0;
    assign stk_top    = '0;
    assign stk_full   = 1'b0;
    assign stk_empty  = 1'b1;
    assign unused_stk = {ret, push, pop};
`endif

    assign pc_plus1 = pc_q + WIDTH'(1);
    assign br_tgt   = pc_q + WIDTH'(sext(32'(branch_offset), OFFSET_W));

    always_comb begin
        src     = SRC_INC;
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (state_q == ST_HALTED) begin
            src = SRC_HOLD;
            if (resume) state_d = ST_RUN;
        end else if (stall) begin
            src = SRC_HOLD;
        end else if (halt) begin
            src     = SRC_HOLD;
            state_d = ST_HALTED;
        end else if (ret_en) begin
            // A ret on an empty stack degrades to a plain increment.
            if (!stk_empty) begin
                src = SRC_RET;
                pop = 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end else if (call) begin
            src = SRC_CALL;
            if (CS_EN) begin
                if (stk_full) ovf_d = 1'b1;
                else          push  = 1'b1;
            end
        end else if (jump) begin
            src = SRC_JMP;
        end else if (branch) begin
            src = SRC_BR;
        end
    end

    always_comb begin
        case (src)
            SRC_BR:            pc_d = br_tgt;
            SRC_JMP, SRC_CALL: pc_d = jump_target;
            SRC_RET:           pc_d = stk_top;
            SRC_HOLD:          pc_d = pc_q;
            default:           pc_d = pc_plus1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            state_q <= ST_RUN;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALTED);
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule
